// File: rtl/tft_capture_writer.sv
// Captures a fixed window of an RGB565 TFT pixel stream into a frame buffer.
// Single clock domain; video inputs are registered once before any edge detection.
module tft_capture_writer #(
  parameter int IMG_WIDTH      = 169,
  parameter int IMG_HEIGHT     = 267,
  parameter int CAP_HBEGIN     = 315,
  parameter int CAP_VBEGIN     = 106,
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic                      clk_ctrl,
  input  logic                      reset_n,
  input  logic                      vid_hs,
  input  logic                      vid_vs,
  input  logic                      vid_de,
  input  logic [15:0]               vid_rgb,
  input  logic                      cap_start,
  input  logic                      cap_continuous,
  output logic                      ram_wea,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
  output logic [15:0]               ram_dina,
  output logic                      cap_busy,
  output logic                      cap_done,
  output logic                      frame_err
);
  // state   | meaning
  // IDLE    | disarmed, waiting for cap_start
  // WAIT_VS | armed, waiting for the next frame start
  // CAPTURE | writing window pixels in raster order
  // DONE    | window complete, one-cycle cap_done
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [11:0] H_LO = 12'(CAP_HBEGIN);
  localparam logic [11:0] H_HI = 12'(CAP_HBEGIN + IMG_WIDTH);
  localparam logic [11:0] V_LO = 12'(CAP_VBEGIN);
  localparam logic [11:0] V_HI = 12'(CAP_VBEGIN + IMG_HEIGHT);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE  = RAM_ADDR_WIDTH'(1);

  state_t                      state, state_nxt;
  logic                        vs_s1, de_s1, vs_d, de_d;
  logic [15:0]                 rgb_s1;
  logic [11:0]                 hcnt, vcnt;
  logic [RAM_ADDR_WIDTH-1:0]   wr_addr;
  logic                        frame_start, line_end, in_window, pix_wr, last_wr, addr_clr;
  logic                        unused_hs;

  // Line sync carries no information beyond vid_de here.
  assign unused_hs = vid_hs;

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1  <= 1'b0;
      de_s1  <= 1'b0;
      rgb_s1 <= '0;
      vs_d   <= 1'b0;
      de_d   <= 1'b0;
    end else begin
      vs_s1  <= vid_vs;
      de_s1  <= vid_de;
      rgb_s1 <= vid_rgb;
      vs_d   <= vs_s1;
      de_d   <= de_s1;
    end
  end

  assign frame_start = vs_d & ~vs_s1;
  assign line_end    = de_d & ~de_s1;

  // hcnt is the index of the pixel currently in stage 1 whenever de_s1 is high.
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (frame_start) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= vcnt + 12'd1;
    end else if (de_s1) begin
      hcnt <= hcnt + 12'd1;
    end
  end

  assign in_window = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
  assign pix_wr    = (state == CAPTURE) && de_s1 && in_window && !frame_start;
  assign last_wr   = pix_wr && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_start)   state_nxt = WAIT_VS;
      WAIT_VS: if (frame_start) state_nxt = CAPTURE;
      CAPTURE: if (last_wr)     state_nxt = DONE;
      DONE:    state_nxt = cap_continuous ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_busy  = (state != IDLE);
    cap_done  = (state == DONE);
    frame_err = (state == CAPTURE) && frame_start;
    addr_clr  = frame_start && ((state == WAIT_VS) || (state == CAPTURE));
  end

  // Write port is a registered stage; ram_dina/ram_addra hold between writes.
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
      wr_addr   <= '0;
    end else begin
      ram_wea <= pix_wr;
      if (pix_wr) begin
        ram_addra <= wr_addr;
        ram_dina  <= rgb_s1;
        wr_addr   <= wr_addr + ADDR_ONE;
      end else if (addr_clr) begin
        wr_addr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tft_capture_writer.sv
// Directed bench for tft_capture_writer: 4x3 window at (2,1) in an 8x6 frame,
// with a scoreboard of expected writes (address, data, cycle) checked by a monitor.
module tb_tft_capture_writer;
  logic        clk_ctrl = 1'b0;
  logic        reset_n  = 1'b1;
  logic        vid_hs   = 1'b1;
  logic        vid_vs   = 1'b1;
  logic        vid_de   = 1'b0;
  logic [15:0] vid_rgb  = '0;
  logic        cap_start = 1'b0;
  logic        cap_continuous = 1'b0;
  logic        ram_wea;
  logic [15:0] ram_addra;
  logic [15:0] ram_dina;
  logic        cap_busy, cap_done, frame_err;

  tft_capture_writer #(
    .IMG_WIDTH(4), .IMG_HEIGHT(3), .CAP_HBEGIN(2), .CAP_VBEGIN(1), .RAM_ADDR_WIDTH(16)
  ) dut (
    .clk_ctrl(clk_ctrl), .reset_n(reset_n), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_de(vid_de), .vid_rgb(vid_rgb), .cap_start(cap_start),
    .cap_continuous(cap_continuous), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .cap_busy(cap_busy), .cap_done(cap_done), .frame_err(frame_err)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb_q[$];
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          cyc = 0;
  int          wr_cnt = 0, done_cnt = 0, err_cnt = 0, idle_cyc = 0;
  logic [15:0] first_data = '0, last_data = '0;
  bit          mdl_armed = 0, mdl_cap = 0;
  int          mdl_addr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wea"},   32'(ram_wea),   0);
    chk({tag, "_addra"}, 32'(ram_addra), 0);
    chk({tag, "_dina"},  32'(ram_dina),  0);
    chk({tag, "_busy"},  32'(cap_busy),  0);
    chk({tag, "_done"},  32'(cap_done),  0);
    chk({tag, "_err"},   32'(frame_err), 0);
  endtask

  always @(posedge clk_ctrl) cyc <= cyc + 1;

  // Monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk_ctrl) begin
    if (ram_wea) begin
      if (wr_cnt == 0) first_data = ram_dina;
      last_data = ram_dina;
      wr_cnt++;
      chk("wr_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr",  32'(ram_addra), 32'(e.addr));
        chk("wr_data",  32'(ram_dina),  32'(e.data));
        chk("wr_cycle", 32'(cyc),       32'(e.cyc));
      end
    end
    if (cap_done)  done_cnt++;
    if (frame_err) err_cnt++;
    if (!cap_busy) idle_cyc++;
  end

  task automatic reset_counts();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; idle_cyc = 0;
  endtask

  task automatic arm();
    @(negedge clk_ctrl);
    cap_start = 1'b1;
    if (!mdl_cap && !mdl_armed) mdl_armed = 1;
    @(negedge clk_ctrl);
    cap_start = 1'b0;
  endtask

  // One 8x6 frame; stops driving pixels at index limit, optionally resets or
  // pulses cap_start at a given pixel index (-1 = never).
  task automatic feed_frame(input int limit, input int rst_pix, input int start_pix);
    bit stop;
    int idx;
    stop = 0;
    @(negedge clk_ctrl);
    vid_vs = 1'b0;
    if (mdl_cap || mdl_armed) begin
      mdl_cap = 1; mdl_armed = 0; mdl_addr = 0;
    end
    @(negedge clk_ctrl);
    @(negedge clk_ctrl);
    vid_vs = 1'b1;
    repeat (3) @(negedge clk_ctrl);
    for (int v = 0; v < 6 && !stop; v++) begin
      for (int h = 0; h < 8; h++) begin
        idx = v * 8 + h;
        if (idx >= limit) begin
          stop = 1;
          break;
        end
        @(negedge clk_ctrl);
        if (idx == rst_pix) begin
          #1;
          chk("wr_before_rst", 32'(wr_cnt), 5);
          reset_n = 1'b0;
          #1;
          chk_outputs_zero("midrst");
          sb_q.delete();
          mdl_cap = 0; mdl_armed = 0;
        end
        cap_start = (idx == start_pix);
        if (cap_start && !mdl_cap && !mdl_armed) mdl_armed = 1;
        vid_de  = 1'b1;
        vid_rgb = {8'(v), 8'(h)};
        if (mdl_cap && v >= 1 && v < 4 && h >= 2 && h < 6) begin
          sb_q.push_back('{16'(mdl_addr), {8'(v), 8'(h)}, cyc + 2});
          mdl_addr++;
          if (mdl_addr == 12) begin
            mdl_cap = 0;
            mdl_armed = cap_continuous;
          end
        end
      end
      @(negedge clk_ctrl);
      vid_de = 1'b0;
      cap_start = 1'b0;
      repeat (2) @(negedge clk_ctrl);
    end
    repeat (4) @(negedge clk_ctrl);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_ctrl);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk_ctrl);

    // single shot
    reset_counts();
    arm();
    chk("s1_busy_armed", 32'(cap_busy), 1);
    feed_frame(48, -1, -1);
    chk("s1_writes", 32'(wr_cnt), 12);
    chk("s1_done", 32'(done_cnt), 1);
    chk("s1_err", 32'(err_cnt), 0);
    chk("s1_busy_end", 32'(cap_busy), 0);
    chk("s1_first_data", 32'(first_data), 32'h0102);
    chk("s1_last_data", 32'(last_data), 32'h0305);
    chk("s1_q_empty", 32'(sb_q.size()), 0);

    // truncated frame then full frame
    reset_counts();
    arm();
    feed_frame(21, -1, -1);
    chk("s2_trunc_writes", 32'(wr_cnt), 7);
    chk("s2_trunc_done", 32'(done_cnt), 0);
    feed_frame(48, -1, -1);
    chk("s2_err", 32'(err_cnt), 1);
    chk("s2_writes", 32'(wr_cnt), 19);
    chk("s2_done", 32'(done_cnt), 1);
    chk("s2_busy_end", 32'(cap_busy), 0);
    chk("s2_q_empty", 32'(sb_q.size()), 0);

    // continuous over three frames
    cap_continuous = 1'b1;
    reset_counts();
    arm();
    idle_cyc = 0;
    repeat (3) feed_frame(48, -1, -1);
    chk("s3_done", 32'(done_cnt), 3);
    chk("s3_writes", 32'(wr_cnt), 36);
    chk("s3_idle_cycles", 32'(idle_cyc), 0);
    chk("s3_busy_end", 32'(cap_busy), 1);
    chk("s3_q_empty", 32'(sb_q.size()), 0);
    @(negedge clk_ctrl);
    reset_n = 1'b0;
    sb_q.delete();
    mdl_cap = 0; mdl_armed = 0;
    cap_continuous = 1'b0;
    repeat (2) @(negedge clk_ctrl);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_ctrl);

    // cap_start ignored while busy (in WAIT_VS and mid-capture)
    reset_counts();
    arm();
    arm();
    feed_frame(48, -1, 12);
    chk("s4_writes", 32'(wr_cnt), 12);
    chk("s4_done", 32'(done_cnt), 1);
    chk("s4_busy_end", 32'(cap_busy), 0);
    chk("s4_q_empty", 32'(sb_q.size()), 0);

    // reset mid-capture, then a frame without arming
    reset_counts();
    arm();
    feed_frame(48, 20, -1);
    chk("s5_writes_total", 32'(wr_cnt), 5);
    @(negedge clk_ctrl);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_ctrl);
    feed_frame(48, -1, -1);
    chk("s5_no_writes", 32'(wr_cnt), 5);
    chk("s5_done", 32'(done_cnt), 0);
    chk("s5_busy", 32'(cap_busy), 0);
    chk("s5_q_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
